// File: rtl/bus_arbiter.sv
// Round-robin arbiter between N bus clients and a single server. It latches the
// winner's request, runs one server transfer with a timeout, and acks the winner.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no transfer; pick the first requester at/after the pointer
// S_LATCH   | capture the winner's address, op and write data
// S_XFER    | srv_rq high; wait for srv_ack or timeout expiry
// S_ACK     | one-cycle ack to the winner; advance the pointer
// S_RELEASE | wait for the winner to drop rq
module bus_arbiter #(
   parameter int N_CLIENTS   = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 4,
   parameter int SRV_TIMEOUT = 15,
   localparam int ID_W       = $clog2(N_CLIENTS)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [N_CLIENTS-1:0]             rq,
   input  logic [N_CLIENTS*ADDR_WIDTH-1:0]  address,
   input  logic [N_CLIENTS-1:0]             wr_ni,
   input  logic [N_CLIENTS*DATA_WIDTH-1:0]  dataW,
   output logic [N_CLIENTS-1:0]             ack,
   output logic [DATA_WIDTH-1:0]            dataR,
   output logic                             srv_rq,
   input  logic                             srv_ack,
   output logic [ADDR_WIDTH-1:0]            srv_addr,
   output logic                             srv_wr_ni,
   output logic [DATA_WIDTH-1:0]            srv_dataW,
   input  logic [DATA_WIDTH-1:0]            srv_dataR,
   output logic [ID_W-1:0]                  grant_id,
   output logic                             busy,
   output logic                             timeout
);

   localparam int CNT_W = $clog2(SRV_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_XFER,
      S_ACK,
      S_RELEASE
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [ID_W-1:0]         ptr_q;
   logic [ID_W-1:0]         winner;
   logic [ID_W-1:0]         idx;
   logic                    found;
   logic [CNT_W-1:0]        cnt_q;
   logic                    expired;
   logic [ADDR_WIDTH-1:0]   addr_arr [N_CLIENTS];
   logic [DATA_WIDTH-1:0]   data_arr [N_CLIENTS];

   for (genvar g = 0; g < N_CLIENTS; g++) begin : g_slice
      assign addr_arr[g] = address[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_arr[g] = dataW[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // First requester at or after the pointer, wrapping past the last client.
   always_comb begin
      winner = ptr_q;
      found  = 1'b0;
      idx    = '0;
      for (int i = 0; i < N_CLIENTS; i++) begin
         idx = ID_W'((int'(ptr_q) + i) % N_CLIENTS);
         if (!found && rq[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   // A same-cycle srv_ack wins over expiry.
   assign expired = (cnt_q == '0) && !srv_ack;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ack     = '0;
      srv_rq  = 1'b0;
      busy    = 1'b1;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (|rq) state_d = S_LATCH;
         end
         S_LATCH: state_d = S_XFER;
         S_XFER: begin
            srv_rq = 1'b1;
            if (srv_ack || expired) state_d = S_ACK;
         end
         S_ACK: begin
            ack[grant_id] = 1'b1;
            state_d       = S_RELEASE;
         end
         S_RELEASE: begin
            if (!rq[grant_id]) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q     <= '0;
         grant_id  <= '0;
         cnt_q     <= '0;
         dataR     <= '0;
         srv_addr  <= '0;
         srv_wr_ni <= 1'b0;
         srv_dataW <= '0;
         timeout   <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (|rq) grant_id <= winner;
            end
            S_LATCH: begin
               srv_addr  <= addr_arr[grant_id];
               srv_wr_ni <= wr_ni[grant_id];
               srv_dataW <= data_arr[grant_id];
               cnt_q     <= CNT_W'(SRV_TIMEOUT - 1);
            end
            S_XFER: begin
               if (srv_ack) begin
                  dataR <= srv_wr_ni ? srv_dataR : '0;
               end else if (cnt_q == '0) begin
                  dataR   <= '0;
                  timeout <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_ACK: begin
               ptr_q <= (grant_id == ID_W'(N_CLIENTS - 1)) ? '0 : grant_id + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with default parameters (4 clients, 8-bit data,
// 4-bit address, timeout 15); the bench plays both the clients and the server.
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  rq;
   logic [15:0] address;
   logic [3:0]  wr_ni;
   logic [31:0] dataW;
   logic [3:0]  ack;
   logic [7:0]  dataR;
   logic        srv_rq;
   logic        srv_ack;
   logic [3:0]  srv_addr;
   logic        srv_wr_ni;
   logic [7:0]  srv_dataW;
   logic [7:0]  srv_dataR;
   logic [1:0]  grant_id;
   logic        busy;
   logic        timeout;

   int n_cmp = 0;
   int n_bad = 0;

   bus_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .rq        (rq),
      .address   (address),
      .wr_ni     (wr_ni),
      .dataW     (dataW),
      .ack       (ack),
      .dataR     (dataR),
      .srv_rq    (srv_rq),
      .srv_ack   (srv_ack),
      .srv_addr  (srv_addr),
      .srv_wr_ni (srv_wr_ni),
      .srv_dataW (srv_dataW),
      .srv_dataR (srv_dataR),
      .grant_id  (grant_id),
      .busy      (busy),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic apply_reset();
      rq      = '0;
      srv_ack = 1'b0;
      reset   = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Server model: waits for srv_rq, answers after lat cycles of srv_rq, and
   // returns the ack vector seen on the cycle after srv_ack.
   task automatic serve(input int lat, input logic [7:0] rd,
                        output logic [3:0] ack_seen, output bit ok);
      ok       = 1'b0;
      ack_seen = '0;
      for (int i = 0; i < 20; i++) begin
         if (srv_rq) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) return;
      repeat (lat - 1) @(negedge clk);
      srv_ack   = 1'b1;
      srv_dataR = rd;
      @(negedge clk);
      ack_seen  = ack;
      srv_ack   = 1'b0;
      srv_dataR = 8'h00;
   endtask

   task automatic wait_srv_rq();
      for (int i = 0; i < 20; i++) begin
         if (srv_rq) break;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++;
      if ({ack, srv_rq, busy, timeout} !== 7'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got ack/srv_rq/busy/timeout=%b want 0", {ack, srv_rq, busy, timeout});
      end
      n_cmp++;
      if ({dataR, grant_id} !== 10'h0) begin
         n_bad++;
         $display("FAIL reset_data: got dataR=%h grant_id=%0d want 0", dataR, grant_id);
      end
      n_cmp++;
      if ({srv_addr, srv_wr_ni, srv_dataW} !== 13'h0) begin
         n_bad++;
         $display("FAIL reset_srv: got addr=%h wr_ni=%b dataW=%h want 0", srv_addr, srv_wr_ni, srv_dataW);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_read();
      logic [3:0] a;
      bit ok;
      apply_reset();
      address = 16'h0500;
      wr_ni   = 4'b0100;
      dataW   = 32'h00EE_0000;
      rq      = 4'b0100;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1 || srv_rq !== 1'b0) begin
         n_bad++;
         $display("FAIL read_latency1: got busy=%b srv_rq=%b want 1/0", busy, srv_rq);
      end
      @(negedge clk);
      n_cmp++;
      if (srv_rq !== 1'b1) begin
         n_bad++;
         $display("FAIL read_latency2: got srv_rq=%b want 1", srv_rq);
      end
      serve(3, 8'hA7, a, ok);
      n_cmp++;
      if (!ok || a !== 4'b0100) begin
         n_bad++;
         $display("FAIL read_ack: got ok=%0d ack=%b want ack=0100", ok, a);
      end
      n_cmp++;
      if (dataR !== 8'hA7 || srv_addr !== 4'h5 || srv_wr_ni !== 1'b1 || grant_id !== 2'd2) begin
         n_bad++;
         $display("FAIL read_data: got dataR=%h addr=%h wr_ni=%b gid=%0d want A7/5/1/2",
                  dataR, srv_addr, srv_wr_ni, grant_id);
      end
      rq = 4'b0000;
      @(negedge clk);
      n_cmp++;
      if (ack !== 4'b0000 || dataR !== 8'hA7) begin
         n_bad++;
         $display("FAIL read_ack_one_cycle: got ack=%b dataR=%h want 0000/A7", ack, dataR);
      end
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL read_release: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] a;
      logic [3:0] exp;
      bit ok;
      apply_reset();
      address = 16'h4321;
      wr_ni   = 4'b1111;
      rq      = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp = 4'b0001 << (k % 4);
         serve(1 + k % 2, 8'h10 + 8'(k), a, ok);
         n_cmp++;
         if (!ok || a !== exp || dataR !== 8'h10 + 8'(k)) begin
            n_bad++;
            $display("FAIL rr_grant%0d: got ok=%0d ack=%b dataR=%h want ack=%b dataR=%h",
                     k, ok, a, dataR, exp, 8'h10 + 8'(k));
         end
         rq = rq & ~a;
         repeat (2) @(negedge clk);
         rq = 4'b1111;
      end
      rq = 4'b0000;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_wrap();
      logic [3:0] a;
      bit ok;
      apply_reset();
      wr_ni = 4'b1111;
      rq    = 4'b0010;
      serve(2, 8'h01, a, ok);
      rq = 4'b0000;
      repeat (2) @(negedge clk);
      rq = 4'b0011;
      serve(2, 8'h02, a, ok);
      n_cmp++;
      if (!ok || a !== 4'b0001) begin
         n_bad++;
         $display("FAIL wrap_first: got ok=%0d ack=%b want 0001", ok, a);
      end
      rq = 4'b0010;
      repeat (2) @(negedge clk);
      serve(2, 8'h03, a, ok);
      n_cmp++;
      if (!ok || a !== 4'b0010 || grant_id !== 2'd1) begin
         n_bad++;
         $display("FAIL wrap_second: got ok=%0d ack=%b gid=%0d want 0010/1", ok, a, grant_id);
      end
      rq = 4'b0000;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_timeout();
      logic [3:0] a;
      bit ok;
      int cnt;
      apply_reset();
      wr_ni = 4'b0001;
      rq    = 4'b0001;
      serve(2, 8'h5A, a, ok);
      rq = 4'b0000;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (dataR !== 8'h5A) begin
         n_bad++;
         $display("FAIL to_preload: got dataR=%h want 5A", dataR);
      end
      address = 16'h0090;
      dataW   = 32'h0000_3C00;
      wr_ni   = 4'b0000;
      rq      = 4'b0010;
      wait_srv_rq();
      n_cmp++;
      if (srv_rq !== 1'b1 || srv_wr_ni !== 1'b0 || srv_dataW !== 8'h3C || srv_addr !== 4'h9) begin
         n_bad++;
         $display("FAIL to_latch: got srv_rq=%b wr_ni=%b dataW=%h addr=%h want 1/0/3C/9",
                  srv_rq, srv_wr_ni, srv_dataW, srv_addr);
      end
      cnt = 0;
      while (srv_rq && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      n_cmp++;
      if (cnt !== 15) begin
         n_bad++;
         $display("FAIL to_srv_rq_cycles: got %0d want 15", cnt);
      end
      n_cmp++;
      if (timeout !== 1'b1 || ack !== 4'b0010 || dataR !== 8'h00) begin
         n_bad++;
         $display("FAIL to_abort: got timeout=%b ack=%b dataR=%h want 1/0010/00", timeout, ack, dataR);
      end
      rq = 4'b0000;
      @(negedge clk);
      n_cmp++;
      if (timeout !== 1'b0 || ack !== 4'b0000) begin
         n_bad++;
         $display("FAIL to_pulse_width: got timeout=%b ack=%b want 0/0000", timeout, ack);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_ack_at_expiry();
      logic [3:0] a;
      bit ok;
      apply_reset();
      wr_ni = 4'b1000;
      rq    = 4'b1000;
      serve(15, 8'hC3, a, ok);
      n_cmp++;
      if (!ok || a !== 4'b1000 || timeout !== 1'b0 || dataR !== 8'hC3) begin
         n_bad++;
         $display("FAIL expiry_ack: got ok=%0d ack=%b timeout=%b dataR=%h want 1000/0/C3",
                  ok, a, timeout, dataR);
      end
      rq = 4'b0000;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [3:0] a;
      bit ok;
      apply_reset();
      wr_ni = 4'b1111;
      rq    = 4'b0010;
      serve(1, 8'h11, a, ok);
      rq = 4'b0000;
      repeat (2) @(negedge clk);
      rq = 4'b0100;
      wait_srv_rq();
      reset = 1'b0;
      #1;
      n_cmp++;
      if (srv_rq !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0) begin
         n_bad++;
         $display("FAIL mid_reset: got srv_rq=%b ack=%b busy=%b gid=%0d want 0/0000/0/0",
                  srv_rq, ack, busy, grant_id);
      end
      @(negedge clk);
      reset = 1'b1;
      rq    = 4'b0101;
      serve(2, 8'h66, a, ok);
      n_cmp++;
      if (!ok || a !== 4'b0001) begin
         n_bad++;
         $display("FAIL mid_restart: got ok=%0d ack=%b want 0001", ok, a);
      end
      rq = 4'b0000;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_stray_and_drop();
      logic [3:0] a;
      logic [3:0] seen;
      bit ok;
      apply_reset();
      srv_ack   = 1'b1;
      srv_dataR = 8'hFF;
      @(negedge clk);
      srv_ack   = 1'b0;
      srv_dataR = 8'h00;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || dataR !== 8'h00 || ack !== 4'b0000 || timeout !== 1'b0) begin
         n_bad++;
         $display("FAIL stray_ack: got busy=%b dataR=%h ack=%b timeout=%b want 0/00/0000/0",
                  busy, dataR, ack, timeout);
      end
      wr_ni = 4'b1001;
      rq    = 4'b1001;
      wait_srv_rq();
      rq = 4'b0001;
      serve(2, 8'h42, a, ok);
      n_cmp++;
      if (!ok || a !== 4'b0001 || dataR !== 8'h42) begin
         n_bad++;
         $display("FAIL drop_first: got ok=%0d ack=%b dataR=%h want 0001/42", ok, a, dataR);
      end
      rq   = 4'b0000;
      seen = '0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         seen |= ack;
      end
      n_cmp++;
      if (seen !== 4'b0000 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL drop_never_acked: got ack_seen=%b busy=%b want 0000/0", seen, busy);
      end
   endtask

   initial begin
      reset     = 1'b1;
      rq        = '0;
      address   = '0;
      wr_ni     = '0;
      dataW     = '0;
      srv_ack   = 1'b0;
      srv_dataR = '0;
      #1 reset  = 1'b0;
      test_reset();
      test_single_read();
      test_round_robin();
      test_wrap();
      test_timeout();
      test_ack_at_expiry();
      test_reset_mid();
      test_stray_and_drop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion want finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
